pulse_arbiter: RTL and testbench

PULSE_ARBITER -- requirements
Module: pulse_arbiter

---
 rtl/pulse_arbiter.sv | 126 ++++++++++++
 tb/tb_pulse_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pulse_arbiter.sv
// Round-robin arbiter that turns rising edges on req into one-shot service
// requests for a single shared resource, with a done handshake and a watchdog.
module pulse_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 start,
  output logic [N-1:0]         pending,
  output logic                 timeout_err
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [N-1:0]  req_q;
  logic [N-1:0]  evt;
  logic [N-1:0]  clr;
  logic [N-1:0]  grant_n, pending_n;
  logic [IW-1:0] grant_id_n;
  logic [IW-1:0] last_id, last_n;
  logic [IW-1:0] pick;
  logic [7:0]    counter, count_n;
  logic          terr_n;
  logic          found;

  assign evt = req & ~req_q;

  // Search upward from the requester after the last one served, wrapping.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (int'(last_id) + k) % N;
      if (!found && pending[IW'(idx)]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_comb begin
    state_n    = state;
    grant_n    = grant;
    grant_id_n = grant_id;
    count_n    = counter;
    terr_n     = timeout_err;
    last_n     = last_id;
    clr        = '0;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (|pending) begin
          grant_n       = '0;
          grant_n[pick] = 1'b1;
          grant_id_n    = pick;
          state_n       = START;
        end
      end
      START: begin
        start   = 1'b1;
        clr     = grant;
        count_n = 8'd0;
        state_n = WAIT;
      end
      WAIT: begin
        // done has priority over the watchdog expiring in the same cycle
        if (done) begin
          grant_n = '0;
          state_n = RELEASE;
        end else if (counter == 8'(TIMEOUT - 1)) begin
          terr_n  = 1'b1;
          grant_n = '0;
          state_n = RELEASE;
        end else begin
          count_n = counter + 8'd1;
        end
      end
      RELEASE: begin
        grant_n = '0;
        last_n  = grant_id;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // A new edge on the bit being cleared keeps it pending.
    pending_n = (pending & ~clr) | evt;
  end

  // req_q resets high so a request held through reset is not seen as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_q       <= '1;
      grant       <= '0;
      grant_id    <= '0;
      pending     <= '0;
      counter     <= 8'd0;
      timeout_err <= 1'b0;
      last_id     <= IW'(N - 1);
    end else begin
      state       <= state_n;
      req_q       <= req;
      grant       <= grant_n;
      grant_id    <= grant_id_n;
      pending     <= pending_n;
      counter     <= count_n;
      timeout_err <= terr_n;
      last_id     <= last_n;
    end
  end

endmodule

// File: tb/tb_pulse_arbiter.sv
// Randomized bench for pulse_arbiter: a service-level model predicts grants,
// and a monitor compares each start pulse against a scoreboard queue.
module tb_pulse_arbiter;

  localparam int N       = 4;
  localparam int IW      = $clog2(N);
  localparam int TIMEOUT = 10;
  localparam int CYCLES  = 3000;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic          done;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_id;
  logic          start;
  logic [N-1:0]  pending;
  logic          timeout_err;

  pulse_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_id    (grant_id),
    .start       (start),
    .pending     (pending),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a service is a span of cycles after a decision edge.
  // age 1 is the start cycle, ages 2..wlen+1 are waiting, wlen+2 is release.
  logic [N-1:0] mpend;
  logic [N-1:0] mreq_q;
  int           mlast;
  int           mgid;
  int           cur;
  int           age;
  int           wlen;
  bit           busy;
  bit           planned_done;
  bit           terr;
  bit           monitor_on = 1'b0;
  bit           want_reset = 1'b0;
  bit           draining   = 1'b0;
  int           q_exp[$];

  task automatic compareValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rrPick();
    for (int k = 1; k <= N; k++) begin
      int id;
      id = (mlast + k) % N;
      if (mpend[id]) return id;
    end
    return 0;
  endfunction

  task automatic resetModel();
    mpend  = '0;
    mreq_q = '1;
    mlast  = N - 1;
    mgid   = 0;
    busy   = 1'b0;
    age    = 0;
    terr   = 1'b0;
    q_exp.delete();
  endtask

  // Advances the model across one rising edge using the inputs just sampled.
  task automatic stepModel();
    logic [N-1:0] evt;
    if (rst) begin
      resetModel();
    end else begin
      evt    = req & ~mreq_q;
      mreq_q = req;
      if (!busy) begin
        if (mpend != '0) begin
          cur          = rrPick();
          mgid         = cur;
          q_exp.push_back(cur);
          busy         = 1'b1;
          age          = 1;
          planned_done = ($urandom_range(0, 3) != 0);
          wlen         = planned_done ? $urandom_range(1, TIMEOUT) : TIMEOUT;
        end
      end else begin
        if (age == 1) mpend[cur] = 1'b0;
        else if (age == wlen + 1 && !planned_done) terr = 1'b1;
        if (age == wlen + 2) begin
          mlast = cur;
          busy  = 1'b0;
          age   = 0;
        end else begin
          age++;
        end
      end
      mpend = mpend | evt;
    end
  endtask

  task automatic applyStimulus(input bit force_rst);
    bit in_wait;
    in_wait = busy && age >= 2 && age <= wlen + 1;
    rst = force_rst;
    if (!force_rst && want_reset && busy && age >= 2 && age <= wlen) begin
      rst        = 1'b1;
      want_reset = 1'b0;
    end
    if (draining) begin
      req = '0;
    end else begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
    end
    if (busy && age == wlen + 1 && planned_done) done = 1'b1;
    else if (in_wait || draining)                done = 1'b0;
    else                                         done = ($urandom_range(0, 3) == 0);
  endtask

  task automatic checkOutput();
    logic [N-1:0] exp_grant;
    bit           exp_start;
    int           id;
    exp_start = busy && age == 1;
    exp_grant = '0;
    if (busy && age >= 1 && age <= wlen + 1) exp_grant[cur] = 1'b1;
    compareValue("start", start, exp_start);
    if (start === 1'b1) begin
      compareValue("start_has_expected", q_exp.size() > 0, 1);
      if (q_exp.size() > 0) begin
        id = q_exp.pop_front();
        compareValue("start_id", grant_id, id);
        compareValue("start_grant", grant, 32'(1) << id);
      end
    end
    compareValue("grant", grant, exp_grant);
    compareValue("grant_id", grant_id, mgid);
    compareValue("pending", pending, mpend);
    compareValue("timeout_err", timeout_err, terr);
  endtask

  always @(negedge clk)
    if (monitor_on) checkOutput();

  initial begin
    rst  = 1'b1;
    req  = 4'b0010;
    done = 1'b0;
    resetModel();
    @(posedge clk);
    stepModel();
    monitor_on = 1'b1;
    for (int c = 0; c < CYCLES; c++) begin
      @(negedge clk);
      if (c == 800 || c == 1600 || c == 2400) want_reset = 1'b1;
      applyStimulus(c < 3);
      @(posedge clk);
      stepModel();
    end
    draining = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      applyStimulus(1'b0);
      @(posedge clk);
      stepModel();
    end
    @(negedge clk);
    monitor_on = 1'b0;
    compareValue("queue_drained", q_exp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
